// File: rtl/debug_overlay_pager.sv
// rtl/debug_overlay_pager.sv - debug overlay page sequencer with frame-coherent snapshot
// Picks the displayed page (manual step or auto-rotate), skips dead pages, snapshots once per frame.
module debug_overlay_pager #(
    parameter int NUM_PAGES     = 4,
    parameter int NUM_HEX_BYTES = 8,
    parameter int DWELL_FRAMES  = 120,
    parameter int SNAP_LINE     = 0,
    localparam int PW           = $clog2(NUM_PAGES),
    localparam int HW           = NUM_HEX_BYTES * 8
) (
    input  logic                            clk_i,
    input  logic                            reset,
    input  logic [9:0]                      screen_y_i,
    input  logic                            enable_i,
    input  logic                            auto_i,
    input  logic                            next_i,
    input  logic [NUM_PAGES-1:0]            page_valid_i,
    input  logic [NUM_PAGES*HW-1:0]         page_hex_i,
    input  logic [NUM_PAGES*16-1:0]         page_bits_i,
    output logic [HW-1:0]                   hex_values_o,
    output logic [7:0]                      debug_bits_0_o,
    output logic [7:0]                      debug_bits_1_o,
    output logic [PW-1:0]                   page_o,
    output logic                            overlay_enable_o,
    output logic                            frame_tick_o
);

    localparam int         DW     = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam logic [9:0] SNAP_Y = SNAP_LINE[9:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_SNAP
    } state_t;

    state_t          state_q, state_d;
    logic [9:0]      prev_y_q, prev_y_d;
    logic            pending_q, pending_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [PW-1:0]   cand_q, cand_d;
    logic [PW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   sel_q, sel_d;
    logic [PW-1:0]   page_q, page_d;
    logic [HW-1:0]   hex_q, hex_d;
    logic [7:0]      bits0_q, bits0_d;
    logic [7:0]      bits1_q, bits1_d;
    logic            oen_q, oen_d;
    logic            tick_q, tick_d;

    logic            fs;
    logic            dwell_last;
    logic            adv;
    logic            adv_take;
    logic [PW-1:0]   cand_nxt;

    always_comb begin
        fs         = (screen_y_i == SNAP_Y) && (prev_y_q != SNAP_Y);
        dwell_last = (dwell_q == DW'(DWELL_FRAMES - 1));
        adv        = fs && (pending_q || next_i || (auto_i && dwell_last));
        adv_take   = adv && (state_q == S_IDLE);
        cand_nxt   = (cand_q == PW'(NUM_PAGES - 1)) ? '0 : cand_q + PW'(1);

        state_d   = state_q;
        prev_y_d  = screen_y_i;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        page_d    = page_q;
        hex_d     = hex_q;
        bits0_d   = bits0_q;
        bits1_d   = bits1_q;
        oen_d     = oen_q;
        tick_d    = 1'b0;

        // Any number of next_i pulses before the frame start collapse into one advance.
        pending_d = (pending_q || next_i) && !adv_take;

        dwell_d = dwell_q;
        if (!auto_i || adv_take) begin
            dwell_d = '0;
        end else if (fs && (state_q == S_IDLE) && !dwell_last) begin
            dwell_d = dwell_q + DW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (fs) begin
                    cand_d  = sel_q;
                    cnt_d   = '0;
                    state_d = adv ? S_SEARCH : S_SNAP;
                end
            end
            S_SEARCH: begin
                if (page_valid_i[cand_nxt]) begin
                    sel_d   = cand_nxt;
                    state_d = S_SNAP;
                end else if (cnt_q == PW'(NUM_PAGES - 2)) begin
                    // Every other page is dead: keep showing the current one.
                    state_d = S_SNAP;
                end else begin
                    cand_d = cand_nxt;
                    cnt_d  = cnt_q + PW'(1);
                end
            end
            S_SNAP: begin
                page_d  = sel_q;
                hex_d   = page_hex_i[int'(sel_q) * HW +: HW];
                bits0_d = page_bits_i[int'(sel_q) * 16 +: 8];
                bits1_d = page_bits_i[int'(sel_q) * 16 + 8 +: 8];
                oen_d   = enable_i && page_valid_i[sel_q];
                tick_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            prev_y_q  <= SNAP_Y;
            pending_q <= 1'b0;
            dwell_q   <= '0;
            cand_q    <= '0;
            cnt_q     <= '0;
            sel_q     <= '0;
            page_q    <= '0;
            hex_q     <= '0;
            bits0_q   <= '0;
            bits1_q   <= '0;
            oen_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_y_q  <= prev_y_d;
            pending_q <= pending_d;
            dwell_q   <= dwell_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            page_q    <= page_d;
            hex_q     <= hex_d;
            bits0_q   <= bits0_d;
            bits1_q   <= bits1_d;
            oen_q     <= oen_d;
            tick_q    <= tick_d;
        end
    end

    assign hex_values_o     = hex_q;
    assign debug_bits_0_o   = bits0_q;
    assign debug_bits_1_o   = bits1_q;
    assign page_o           = page_q;
    assign overlay_enable_o = oen_q;
    assign frame_tick_o     = tick_q;

endmodule

// File: tb/tb_debug_overlay_pager.sv
// tb/tb_debug_overlay_pager.sv - scoreboard bench for debug_overlay_pager
module tb_debug_overlay_pager;

    localparam int NP = 4;
    localparam int NB = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [9:0]      screen_y;
    logic            enable;
    logic            auto_r;
    logic            next_r;
    logic [NP-1:0]   page_valid;
    logic [7:0]      salt;
    logic [NP*NB*8-1:0] page_hex;
    logic [NP*16-1:0]   page_bits;
    logic [NB*8-1:0] hex_values;
    logic [7:0]      bits0;
    logic [7:0]      bits1;
    logic [1:0]      page_o;
    logic            overlay_en;
    logic            frame_tick;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          page;
        logic [63:0] hex;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic        en;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    debug_overlay_pager #(
        .NUM_PAGES(NP), .NUM_HEX_BYTES(NB), .DWELL_FRAMES(3), .SNAP_LINE(0)
    ) dut (
        .clk_i(clk), .reset(rst), .screen_y_i(screen_y), .enable_i(enable),
        .auto_i(auto_r), .next_i(next_r), .page_valid_i(page_valid),
        .page_hex_i(page_hex), .page_bits_i(page_bits),
        .hex_values_o(hex_values), .debug_bits_0_o(bits0), .debug_bits_1_o(bits1),
        .page_o(page_o), .overlay_enable_o(overlay_en), .frame_tick_o(frame_tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] exp_hex(input int p, input logic [7:0] s);
        logic [63:0] r;
        for (int b = 0; b < NB; b++) r[b*8 +: 8] = 8'(p * 16 + b) ^ s;
        return r;
    endfunction

    always_comb begin
        page_hex  = '0;
        page_bits = '0;
        for (int p = 0; p < NP; p++) begin
            page_hex[p*NB*8 +: NB*8] = exp_hex(p, salt);
            page_bits[p*16 +: 8]     = 8'(8'hA0 + p);
            page_bits[p*16+8 +: 8]   = 8'(8'h50 + p);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic push(input int p, input logic en, input int at);
        exp_t e;
        e.page = p;
        e.hex  = exp_hex(p, salt);
        e.b0   = 8'(8'hA0 + p);
        e.b1   = 8'(8'h50 + p);
        e.en   = en;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && frame_tick) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tick: got tick with page %0d, expected none (cyc %0d)", page_o, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("snap_page", 64'(page_o), 64'(e.page));
                chk("snap_hex", hex_values, e.hex);
                chk("snap_bits", {48'h0, bits1, bits0}, {48'h0, e.b1, e.b0});
                chk("snap_en", 64'(overlay_en), 64'(e.en));
                chk("snap_latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One raster frame; k = SEARCH cycles expected before the snapshot.
    task automatic frame(input int lines, input bit expt, input int ep, input logic een,
                         input int k, input int na, input int nb, input int aoff);
        for (int y = 0; y < lines; y++) begin
            screen_y = 10'(y);
            next_r   = (y == na) || (y == nb);
            if (y == aoff) auto_r = 1'b0;
            if (y == 0 && expt) push(ep, een, cyc + 2 + k);
            tick();
        end
        next_r = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_page"}, 64'(page_o), 64'd0);
        chk({nm, "_hex"}, hex_values, 64'd0);
        chk({nm, "_bits"}, {48'h0, bits1, bits0}, 64'd0);
        chk({nm, "_en_tick"}, {62'h0, overlay_en, frame_tick}, 64'd0);
    endtask

    initial begin
        logic [63:0] old_hex;
        rst = 1'b1; screen_y = '0; enable = 1'b1; auto_r = 1'b0; next_r = 1'b0;
        page_valid = 4'hF; salt = 8'h00;
        tick(); tick();
        chk_zero("reset");
        rst = 1'b0;

        // Full rasters: first sweep has no frame start (prev_y resets to SNAP_LINE).
        frame(525, 0, 0, 1, 0, -1, -1, -1);
        frame(525, 1, 0, 1, 0, -1, -1, -1);
        frame(525, 1, 0, 1, 0, -1, -1, -1);

        // Two pulses in one frame -> single advance.
        frame(8, 1, 0, 1, 0, 3, 5, -1);
        frame(8, 1, 1, 1, 1, -1, -1, -1);

        // Skipping dead pages and wrap.
        page_valid = 4'b1001;
        frame(8, 1, 1, 0, 0, 2, -1, -1);
        frame(8, 1, 3, 1, 2, 2, -1, -1);
        frame(8, 1, 0, 1, 1, 2, -1, -1);
        frame(8, 1, 3, 1, 3, -1, -1, -1);
        frame(8, 1, 0, 1, 1, 0, -1, -1);

        // Auto rotate every third frame; dropping auto mid-dwell restarts the count.
        page_valid = 4'hF;
        auto_r = 1'b1;
        frame(8, 1, 0, 1, 0, -1, -1, -1);
        frame(8, 1, 0, 1, 0, -1, -1, -1);
        frame(8, 1, 1, 1, 1, -1, -1, -1);
        frame(8, 1, 1, 1, 0, -1, -1, -1);
        frame(8, 1, 1, 1, 0, -1, -1, -1);
        frame(8, 1, 2, 1, 1, -1, -1, -1);
        frame(8, 1, 2, 1, 0, -1, -1, 3);
        auto_r = 1'b1;
        frame(8, 1, 2, 1, 0, -1, -1, -1);
        frame(8, 1, 2, 1, 0, -1, -1, -1);
        frame(8, 1, 3, 1, 1, -1, -1, -1);
        auto_r = 1'b0;

        // No valid page: page holds, overlay disabled.
        page_valid = 4'h0;
        frame(8, 1, 3, 0, 0, 2, -1, -1);
        frame(8, 1, 3, 0, 3, -1, -1, -1);

        // Source data change mid-frame must not reach outputs until next frame start.
        page_valid = 4'hF;
        frame(4, 1, 3, 1, 0, -1, -1, -1);
        old_hex = exp_hex(3, salt);
        salt = 8'h5A;
        for (int y = 4; y < 8; y++) begin
            screen_y = 10'(y);
            tick();
        end
        chk("midframe_hex_hold", hex_values, old_hex);
        chk("midframe_page_hold", 64'(page_o), 64'd3);
        frame(8, 1, 3, 1, 0, -1, -1, -1);

        // Reset while searching.
        screen_y = 10'd0;
        next_r = 1'b1;
        tick();
        next_r = 1'b0;
        rst = 1'b1;
        #1;
        chk_zero("reset_search");
        tick();
        rst = 1'b0;
        for (int y = 1; y < 8; y++) begin
            screen_y = 10'(y);
            tick();
        end
        frame(8, 1, 0, 1, 0, -1, -1, -1);

        tick(); tick(); tick();
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_tick: got none, expected snapshot of page %0d at cyc %0d", e.page, e.cyc);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
